// File: rtl/lg_bist_pkg.sv
// rtl/lg_bist_pkg.sv - shared types, vector table and LFSR helpers for the NAND-block BIST
package lg_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_FIN
  } state_e;

  localparam int DIR_CNT = 7;

  // Parked value on the gate inputs: only OC asserted.
  localparam logic [13:0] IDLE_VEC = 14'h2000;

  // Directed vectors, bit 0 = A .. bit 12 = M, bit 13 = OC.
  localparam logic [0:DIR_CNT-1][13:0] DIR_VEC = {
    14'h2000,  // none
    14'h2003,  // A,B
    14'h2007,  // A..C
    14'h200F,  // A..D
    14'h20FF,  // A..H
    14'h0FFF,  // A..L with OC low
    14'h3FFF   // A..M
  };

  // Fan-in of each NAND output Y, Y1..Y5, counted from input A.
  localparam logic [0:5][3:0] NAND_W = {4'd2, 4'd3, 4'd4, 4'd8, 4'd12, 4'd13};

  // Feedback taps 14,5,3,1 (1-based) of the Fibonacci LFSR.
  localparam logic [13:0] LFSR_TAPS = 14'h2015;

  function automatic logic [13:0] lfsr_step(input logic [13:0] s);
    return {s[12:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [13:0] dir_vec(input logic [2:0] i);
    case (i)
      3'd0:    return DIR_VEC[0];
      3'd1:    return DIR_VEC[1];
      3'd2:    return DIR_VEC[2];
      3'd3:    return DIR_VEC[3];
      3'd4:    return DIR_VEC[4];
      3'd5:    return DIR_VEC[5];
      3'd6:    return DIR_VEC[6];
      default: return IDLE_VEC;
    endcase
  endfunction

endpackage

// File: rtl/lg_bist_ref.sv
// rtl/lg_bist_ref.sv - combinational reference model of the multi-input NAND gate block
module lg_bist_ref
  import lg_bist_pkg::*;
(
  input  logic [13:0] vec_i,
  output logic [5:0]  exp_o,
  output logic [5:0]  mask_o
);

  for (genvar k = 0; k < 6; k++) begin : g_nand
    localparam int W = int'(NAND_W[k]);
    assign exp_o[k] = ~&vec_i[W-1:0];
  end

  // Y4 is not checked while OC is low.
  assign mask_o = {1'b1, vec_i[13], 4'hF};

endmodule

// File: rtl/lg_bist_seq.sv
// rtl/lg_bist_seq.sv - BIST sequencer driving directed and LFSR vectors into the NAND gate block
module lg_bist_seq
  import lg_bist_pkg::*;
#(
  parameter int          SETTLE_CYC = 4,
  parameter int          N_RAND     = 16,
  parameter logic [13:0] LFSR_SEED  = 14'h1ACE,
  parameter int          CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       dut_out,
  output logic [13:0]      dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail
);

  localparam int               SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]    SETTLE_INIT = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIR_LAST    = CNT_W'(DIR_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(DIR_CNT - 1 + N_RAND);

  state_e           state_q;
  logic [CNT_W-1:0] idx_q;
  logic [SW-1:0]    settle_q;
  logic [13:0]      lfsr_q;
  logic [13:0]      dut_in_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [CNT_W-1:0] first_fail_q;

  logic [13:0]      cur_vec;
  logic [5:0]       exp_w;
  logic [5:0]       mask_w;
  logic             mismatch;

  // The reference sees the registered vector, which is stable through SAMPLE.
  lg_bist_ref u_ref (
    .vec_i  (dut_in_q),
    .exp_o  (exp_w),
    .mask_o (mask_w)
  );

  assign cur_vec  = (idx_q > DIR_LAST) ? lfsr_q : dir_vec(idx_q[2:0]);
  assign mismatch = |((dut_out ^ exp_w) & mask_w);

  // Test sequencer: walks every vector through apply / settle / sample / next.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      lfsr_q       <= LFSR_SEED;
      dut_in_q     <= IDLE_VEC;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q      <= ST_APPLY;
            idx_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '1;
          end
        end
        ST_APPLY: begin
          dut_in_q <= cur_vec;
          settle_q <= SETTLE_INIT;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (fail_cnt_q != '1) begin
              fail_cnt_q <= fail_cnt_q + CNT_ONE;
            end
            if (first_fail_q == '1) begin
              first_fail_q <= idx_q;
            end
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q  <= ST_FIN;
            done_q   <= 1'b1;
            pass_q   <= (fail_cnt_q == '0);
            busy_q   <= 1'b0;
            dut_in_q <= IDLE_VEC;
          end else begin
            idx_q <= idx_q + CNT_ONE;
            // The seed itself is the first random vector, so only step once past it.
            if (idx_q > DIR_LAST) begin
              lfsr_q <= lfsr_step(lfsr_q);
            end
            state_q <= ST_APPLY;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Abort overrides whatever the running state decided this cycle.
      if (abort && busy_q) begin
        state_q  <= ST_IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        pass_q   <= 1'b0;
        dut_in_q <= IDLE_VEC;
      end
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_lg_bist_seq.sv
// tb/tb_lg_bist_seq.sv - directed self-checking bench for the NAND-block BIST sequencer
module tb_lg_bist_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        start0, abort0, start1, abort1;
  logic [5:0]  dut_out0, dut_out1;
  logic [13:0] dut_in0, dut_in1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0]  fail_cnt0, first_fail0, fail_cnt1, first_fail1;
  logic [13:0] ref_vec;
  logic [5:0]  ref_exp, ref_mask;

  int fault_mode;
  int n_pass;
  int n_total;

  logic [13:0] tb_dir  [7] = '{14'h2000, 14'h2003, 14'h2007, 14'h200F, 14'h20FF, 14'h0FFF, 14'h3FFF};
  logic [5:0]  tb_exp  [7] = '{6'h3F, 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00};
  logic [5:0]  tb_mask [7] = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h2F, 6'h3F};

  // Behavioural gate block with optional planted faults.
  function automatic logic [5:0] gate_model(input logic [13:0] v, input int fm);
    int          w [6];
    logic [13:0] m;
    logic [5:0]  y;
    w = '{2, 3, 4, 8, 12, 13};
    for (int k = 0; k < 6; k++) begin
      m    = (14'h1 << w[k]) - 14'h1;
      y[k] = ((v & m) != m);
    end
    if (fm == 1) y[2] = 1'b1;
    if (fm == 2 && !v[13]) y[4] = 1'b1;
    return y;
  endfunction

  function automatic logic [13:0] lfsr_model(input logic [13:0] s);
    return {s[12:0], s[13] ^ s[4] ^ s[2] ^ s[0]};
  endfunction

  assign dut_out0 = gate_model(dut_in0, fault_mode);
  assign dut_out1 = gate_model(dut_in1, 0);

  lg_bist_seq #(.SETTLE_CYC(4), .N_RAND(0), .LFSR_SEED(14'h1ACE), .CNT_W(8)) u_dut0 (
    .CLK(CLK), .RST(RST), .start(start0), .abort(abort0), .dut_out(dut_out0),
    .dut_in(dut_in0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_cnt(fail_cnt0), .first_fail(first_fail0)
  );

  lg_bist_seq #(.SETTLE_CYC(4), .N_RAND(16), .LFSR_SEED(14'h1ACE), .CNT_W(8)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .abort(abort1), .dut_out(dut_out1),
    .dut_in(dut_in1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fail_cnt1), .first_fail(first_fail1)
  );

  lg_bist_ref u_ref (.vec_i(ref_vec), .exp_o(ref_exp), .mask_o(ref_mask));

  // Leaves the bench at the negedge of cycle 1 (start was cycle 0).
  task automatic pulse_start(input bit sel);
    @(negedge CLK);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, inout int c, output bit seen);
    seen = 1'b0;
    while (!seen && c < budget) begin
      if ((sel ? done1 : done0) === 1'b1) seen = 1'b1;
      else begin
        @(negedge CLK);
        c++;
      end
    end
  endtask

  task automatic step_to(inout int c, input int target);
    while (c < target) begin
      @(negedge CLK);
      c++;
    end
  endtask

  task automatic test_reset();
    n_total++; if (dut_in0 !== 14'h2000) $display("FAIL reset_dut_in: got %h expected 2000", dut_in0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else n_pass++;
    n_total++; if (done0 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done0); else n_pass++;
    n_total++; if (pass0 !== 1'b0) $display("FAIL reset_pass: got %b expected 0", pass0); else n_pass++;
    n_total++; if (fail_cnt0 !== 8'h00) $display("FAIL reset_fail_cnt: got %h expected 00", fail_cnt0); else n_pass++;
    n_total++; if (first_fail0 !== 8'h00) $display("FAIL reset_first_fail: got %h expected 00", first_fail0); else n_pass++;
    n_total++; if (dut_in1 !== 14'h2000) $display("FAIL reset_dut_in1: got %h expected 2000", dut_in1); else n_pass++;
  endtask

  task automatic test_ref_model();
    for (int i = 0; i < 7; i++) begin
      ref_vec = tb_dir[i];
      #1;
      n_total++; if (ref_exp !== tb_exp[i]) $display("FAIL ref_exp[%0d]: got %h expected %h", i, ref_exp, tb_exp[i]); else n_pass++;
      n_total++; if (ref_mask !== tb_mask[i]) $display("FAIL ref_mask[%0d]: got %h expected %h", i, ref_mask, tb_mask[i]); else n_pass++;
    end
  endtask

  task automatic test_golden();
    int c;
    bit seen;
    fault_mode = 0;
    pulse_start(1'b0);
    c = 1;
    n_total++; if (busy0 !== 1'b1) $display("FAIL golden_busy: got %b expected 1", busy0); else n_pass++;
    wait_done(1'b0, 300, c, seen);
    n_total++; if (!seen) $display("FAIL golden_timeout: got no done expected done"); else n_pass++;
    n_total++; if (c !== 50) $display("FAIL golden_done_cycle: got %0d expected 50", c); else n_pass++;
    n_total++; if (pass0 !== 1'b1) $display("FAIL golden_pass: got %b expected 1", pass0); else n_pass++;
    n_total++; if (fail_cnt0 !== 8'h00) $display("FAIL golden_fail_cnt: got %h expected 00", fail_cnt0); else n_pass++;
    n_total++; if (first_fail0 !== 8'hFF) $display("FAIL golden_first_fail: got %h expected FF", first_fail0); else n_pass++;
    n_total++; if (busy0 !== 1'b0 || dut_in0 !== 14'h2000) $display("FAIL golden_fin: got busy %b dut_in %h expected 0 2000", busy0, dut_in0); else n_pass++;
    @(negedge CLK);
    n_total++; if (done0 !== 1'b0) $display("FAIL golden_done_width: got %b expected 0", done0); else n_pass++;
  endtask

  task automatic test_stuck_y2();
    int c;
    bit seen;
    fault_mode = 1;
    pulse_start(1'b0);
    c = 1;
    wait_done(1'b0, 300, c, seen);
    n_total++; if (!seen || c != 50) $display("FAIL stuck_done: got seen %b cycle %0d expected 1 50", seen, c); else n_pass++;
    n_total++; if (pass0 !== 1'b0) $display("FAIL stuck_pass: got %b expected 0", pass0); else n_pass++;
    n_total++; if (fail_cnt0 !== 8'd4) $display("FAIL stuck_fail_cnt: got %0d expected 4", fail_cnt0); else n_pass++;
    n_total++; if (first_fail0 !== 8'd3) $display("FAIL stuck_first_fail: got %0d expected 3", first_fail0); else n_pass++;
    fault_mode = 0;
  endtask

  task automatic test_oc_mask();
    int c;
    bit seen;
    fault_mode = 2;
    pulse_start(1'b0);
    c = 1;
    wait_done(1'b0, 300, c, seen);
    n_total++; if (!seen) $display("FAIL ocmask_timeout: got no done expected done"); else n_pass++;
    n_total++; if (pass0 !== 1'b1) $display("FAIL ocmask_pass: got %b expected 1", pass0); else n_pass++;
    n_total++; if (fail_cnt0 !== 8'h00) $display("FAIL ocmask_fail_cnt: got %h expected 00", fail_cnt0); else n_pass++;
    n_total++; if (first_fail0 !== 8'hFF) $display("FAIL ocmask_first_fail: got %h expected FF", first_fail0); else n_pass++;
    fault_mode = 0;
  endtask

  task automatic test_random();
    int          c;
    int          i_vec;
    bit          seen;
    logic [13:0] lf;
    logic [13:0] expv;
    lf    = 14'h1ACE;
    i_vec = 0;
    seen  = 1'b0;
    pulse_start(1'b1);
    c = 1;
    while (!seen && c < 400) begin
      if (done1 === 1'b1) seen = 1'b1;
      else begin
        // Vector i is on the pins from the first SETTLE cycle, cycle 7*i+2.
        if (i_vec < 23 && c == 7 * i_vec + 2) begin
          expv = (i_vec < 7) ? tb_dir[i_vec] : lf;
          n_total++; if (dut_in1 !== expv) $display("FAIL rand_vec[%0d]: got %h expected %h", i_vec, dut_in1, expv); else n_pass++;
          if (i_vec == 7) begin
            n_total++; if (dut_in1 !== 14'h1ACE) $display("FAIL rand_seed: got %h expected 1ACE", dut_in1); else n_pass++;
          end
          if (i_vec == 8) begin
            n_total++; if (dut_in1 !== 14'h359D) $display("FAIL rand_step1: got %h expected 359D", dut_in1); else n_pass++;
          end
          if (i_vec >= 7) lf = lfsr_model(lf);
          i_vec++;
        end
        @(negedge CLK);
        c++;
      end
    end
    n_total++; if (!seen || c != 162) $display("FAIL rand_done: got seen %b cycle %0d expected 1 162", seen, c); else n_pass++;
    n_total++; if (i_vec !== 23) $display("FAIL rand_count: got %0d expected 23", i_vec); else n_pass++;
    n_total++; if (pass1 !== 1'b1 || fail_cnt1 !== 8'h00) $display("FAIL rand_pass: got pass %b cnt %h expected 1 00", pass1, fail_cnt1); else n_pass++;
  endtask

  task automatic test_abort();
    int c;
    bit seen;
    pulse_start(1'b0);
    c = 1;
    step_to(c, 18);
    n_total++; if (dut_in0 !== 14'h2007 || busy0 !== 1'b1) $display("FAIL abort_pre: got dut_in %h busy %b expected 2007 1", dut_in0, busy0); else n_pass++;
    abort0 = 1'b1;
    @(negedge CLK);
    c++;
    abort0 = 1'b0;
    n_total++; if (busy0 !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy0); else n_pass++;
    n_total++; if (dut_in0 !== 14'h2000) $display("FAIL abort_dut_in: got %h expected 2000", dut_in0); else n_pass++;
    n_total++; if (pass0 !== 1'b0) $display("FAIL abort_pass: got %b expected 0", pass0); else n_pass++;
    n_total++; if (fail_cnt0 !== 8'h00 || first_fail0 !== 8'hFF) $display("FAIL abort_partial: got cnt %h first %h expected 00 FF", fail_cnt0, first_fail0); else n_pass++;
    n_total++; if (done0 !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", done0); else n_pass++;
    // Start two cycles after the abort takes effect.
    pulse_start(1'b0);
    c = 1;
    wait_done(1'b0, 300, c, seen);
    n_total++; if (!seen || c != 50) $display("FAIL abort_rerun_done: got seen %b cycle %0d expected 1 50", seen, c); else n_pass++;
    n_total++; if (pass0 !== 1'b1 || fail_cnt0 !== 8'h00) $display("FAIL abort_rerun_pass: got pass %b cnt %h expected 1 00", pass0, fail_cnt0); else n_pass++;
  endtask

  task automatic test_abort_start_tie();
    @(negedge CLK);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge CLK);
    start0 = 1'b0;
    abort0 = 1'b0;
    n_total++; if (busy0 !== 1'b0) $display("FAIL tie_busy: got %b expected 0", busy0); else n_pass++;
    @(negedge CLK);
    n_total++; if (busy0 !== 1'b0 || dut_in0 !== 14'h2000) $display("FAIL tie_idle: got busy %b dut_in %h expected 0 2000", busy0, dut_in0); else n_pass++;
  endtask

  task automatic test_start_ignored_and_rst();
    int c;
    bit seen;
    bit saw_done;
    pulse_start(1'b0);
    c = 1;
    step_to(c, 10);
    start0 = 1'b1;
    @(negedge CLK);
    c++;
    start0 = 1'b0;
    step_to(c, 16);
    n_total++; if (dut_in0 !== 14'h2007) $display("FAIL ignore_start_idx2: got %h expected 2007", dut_in0); else n_pass++;
    step_to(c, 31);
    n_total++; if (dut_in0 !== 14'h20FF || busy0 !== 1'b1) $display("FAIL rst_pre_idx4: got dut_in %h busy %b expected 20FF 1", dut_in0, busy0); else n_pass++;
    RST = 1'b1;
    #1;
    n_total++; if (busy0 !== 1'b0 || dut_in0 !== 14'h2000) $display("FAIL rst_async: got busy %b dut_in %h expected 0 2000", busy0, dut_in0); else n_pass++;
    n_total++; if (first_fail0 !== 8'h00 || fail_cnt0 !== 8'h00) $display("FAIL rst_counts: got first %h cnt %h expected 00 00", first_fail0, fail_cnt0); else n_pass++;
    n_total++; if (first_fail1 !== 8'h00 || pass1 !== 1'b0) $display("FAIL rst_dut1: got first %h pass %b expected 00 0", first_fail1, pass1); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (done0 === 1'b1) saw_done = 1'b1;
    end
    n_total++; if (busy0 !== 1'b0 || dut_in0 !== 14'h2000 || saw_done) $display("FAIL rst_stays_idle: got busy %b dut_in %h done %b expected 0 2000 0", busy0, dut_in0, saw_done); else n_pass++;
    pulse_start(1'b0);
    c = 1;
    wait_done(1'b0, 300, c, seen);
    n_total++; if (!seen || c != 50 || pass0 !== 1'b1) $display("FAIL rst_rerun: got seen %b cycle %0d pass %b expected 1 50 1", seen, c, pass0); else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    fault_mode = 0;
    ref_vec    = 14'h0;
    RST        = 1'b1;
    start0     = 1'b0;
    abort0     = 1'b0;
    start1     = 1'b0;
    abort1     = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b0;
    test_ref_model();
    test_golden();
    test_stuck_y2();
    test_oc_mask();
    test_random();
    test_abort();
    test_abort_start_tie();
    test_start_ignored_and_rst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
